vga_fetch_sched: RTL and testbench
==================================

# vga_fetch_sched

Memory scheduler between the VGA timing generator and a single-port framebuffer RAM shared with a host write port. During horizontal blanking it fetches the next framebuffer line into a double-buffered line buffer, with absolute priority. In all other cycles it grants host writes through a valid/ready handshake. It also keeps a saturating host-stall counter for software tuning.

## Interface
Parameters:
- AW, 15: framebuffer word-address width
- DW, 16: framebuffer word width (4 pixels at 4 bpp)
- WORDS_PER_LINE, 40: words fetched per framebuffer line; must be ≤ 150
- LB_AW, 6: line-buffer word-address width
- LINE_SHIFT, 2: each framebuffer line is shown on 2^LINE_SHIFT scanlines
- BASE, 0: framebuffer base word address

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset; asynchronous and active-high
- h_cnt  in  10  horizontal counter from the timing generator (0..799)
- v_cnt  in  10  vertical counter from the timing generator (0..524)
- host_valid  in  1  host write request
- host_ready  out  1  host write accepted when high with host_valid
- host_addr  in  AW  host write address
- host_data  in  DW  host write data
- mem_re  out  1  framebuffer read strobe; data returns next cycle
- mem_we  out  1  framebuffer write strobe
- mem_addr  out  AW  framebuffer address
- mem_wdata  out  DW  framebuffer write data
- mem_rdata  in  DW  framebuffer read data (1-cycle latency)
- lb_we  out  1  line-buffer write strobe
- lb_bank  out  1  line-buffer bank being written (equals ~disp_bank)
- lb_waddr  out  LB_AW  line-buffer word address
- lb_wdata  out  DW  line-buffer write data
- disp_bank  out  1  bank the pixel path reads
- fetch_busy  out  1  high while in FETCH
- stall_cnt  out  16  host stall cycles, saturating
- stall_clr  in  1  synchronous clear of stall_cnt

## Operation
- v_next = 0 if v_cnt == 524, else v_cnt + 1.
- trigger = (h_cnt == 640) && (v_next < 480) && (v_next[LINE_SHIFT-1:0] == 0).
- Trigger fires only when a new framebuffer line is needed: 120 fetches per frame with the defaults.
- FSM states:
  - IDLE: trigger → FETCH, word index w cleared; otherwise stays IDLE.
  - FETCH: w increments each cycle; after issuing word WORDS_PER_LINE-1 → DONE.
  - DONE: 1 cycle, waits for the final read data → IDLE.
- Fetch address: BASE + (v_next >> LINE_SHIFT) * WORDS_PER_LINE + w, computed at AW width; wraparound is silent.
- Line-buffer writes: lb_waddr = w delayed by one cycle; lb_wdata = mem_rdata; lb_bank = ~disp_bank throughout the fetch.
- disp_bank toggles on the cycle after the last lb_we, never earlier. No toggle occurs if the fetch is aborted by reset.
- Host grant: host_ready = (state == IDLE) && !trigger, combinational. Display fetch always wins a coincident request.
- Accepted host write: mem_we = 1 with mem_addr = host_addr and mem_wdata = host_data on the following cycle.
- Outputs mem_re and mem_we are never high together.
- Stall counting: stall_cnt increments on each cycle with host_valid && !host_ready and saturates at 0xFFFF. stall_clr has priority over increment.
- Outside FETCH, a read never occurs.

## Timing
- Reset (asynchronous, any time including mid-fetch) forces:
  - state IDLE, w = 0, disp_bank = 0, stall_cnt = 0
  - mem_re, mem_we, lb_we = 0; mem_addr, mem_wdata, lb_waddr, lb_wdata = 0
  - host_ready follows its equation from IDLE
- Fetch sequence with trigger sampled at cycle T, W = WORDS_PER_LINE:
  - mem_re high at T+1 .. T+W with addresses word 0 .. W-1.
  - lb_we high at T+2 .. T+W+1.
  - disp_bank toggles at T+W+2.
  - fetch_busy high at T+1 .. T+W.
  - host_ready low at T .. T+W+1; earliest following host write reaches memory at T+W+3.
- Host writes: a write accepted at T-1 drives mem_we at T, so there is no collision with the fetch. Throughput is 1 write per cycle while IDLE.
- The fetch (W+2 cycles) completes inside the 160-cycle blanking before h_cnt wraps to 0.

## Test plan
- Reset mid-fetch: assert rst at T+10 with W = 40 → all outputs 0, disp_bank = 0. After release, host_ready = 1 with h_cnt = 100.
- Line fetch: v_cnt = 3, h_cnt = 640 → mem_re for 40 cycles at addresses 40..79; lb_we at T+2..T+41 with lb_waddr 0..39 and lb_bank = 1; disp_bank becomes 1 at T+42.
- No fetch on repeat lines: v_cnt = 4 at h_cnt = 640 (v_next = 5) → no mem_re, host_ready stays 1.
- Frame wrap: v_cnt = 524, h_cnt = 640 → fetch of addresses 0..39.
- No fetch at last line: v_cnt = 479 → no fetch.
- Collision: host_valid held high across T → host_ready = 0 at T..T+41; write appears at T+43 with the held addr/data; stall_cnt = 42. Pulse stall_clr, then hold 70000 stall cycles → stall_cnt = 0xFFFF.

Source files
------------

// File: rtl/vga_fetch_sched_if.sv
// ---------------------------------------------------------------------------
// vga_fetch_sched_if
// Bundles everything the fetch scheduler exchanges with its surroundings:
//   - timing-generator counters (h_cnt, v_cnt)
//   - host write port (valid/ready, addr, data)
//   - framebuffer RAM port (read/write strobes, addr, wdata, rdata)
//   - line-buffer write port (we, bank, waddr, wdata) and display bank select
//   - status/tuning (fetch_busy, stall_cnt, stall_clr)
// Modports:
//   slave  - the scheduler itself
//   master - whatever drives the scheduler (timing gen, host, RAM, bench)
// ---------------------------------------------------------------------------
interface vga_fetch_sched_if #(
  parameter int AW    = 15,
  parameter int DW    = 16,
  parameter int LB_AW = 6
);
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             host_valid;
  logic             host_ready;
  logic [AW-1:0]    host_addr;
  logic [DW-1:0]    host_data;
  logic             mem_re;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [DW-1:0]    mem_rdata;
  logic             lb_we;
  logic             lb_bank;
  logic [LB_AW-1:0] lb_waddr;
  logic [DW-1:0]    lb_wdata;
  logic             disp_bank;
  logic             fetch_busy;
  logic [15:0]      stall_cnt;
  logic             stall_clr;

  modport slave (
    input  h_cnt, v_cnt, host_valid, host_addr, host_data, mem_rdata, stall_clr,
    output host_ready, mem_re, mem_we, mem_addr, mem_wdata,
           lb_we, lb_bank, lb_waddr, lb_wdata, disp_bank, fetch_busy, stall_cnt
  );

  modport master (
    output h_cnt, v_cnt, host_valid, host_addr, host_data, mem_rdata, stall_clr,
    input  host_ready, mem_re, mem_we, mem_addr, mem_wdata,
           lb_we, lb_bank, lb_waddr, lb_wdata, disp_bank, fetch_busy, stall_cnt
  );
endinterface

// File: rtl/vga_fetch_sched.sv
// ---------------------------------------------------------------------------
// vga_fetch_sched
// Arbitrates a single-port framebuffer RAM between display line fetches and
// host writes. At h_cnt == 640 of a scanline that starts a new framebuffer
// line, it burst-reads WORDS_PER_LINE words into the back bank of a
// double-buffered line buffer, then flips the display bank. Host writes are
// granted only while no fetch is running or about to start, and a
// saturating counter records how many cycles the host spent waiting.
// Ports:
//   clk  - pixel clock
//   rst  - asynchronous active-high reset
//   bus  - vga_fetch_sched_if.slave (counters, host port, RAM port,
//          line-buffer port, status)
// ---------------------------------------------------------------------------
module vga_fetch_sched #(
  parameter int AW             = 15,
  parameter int DW             = 16,
  parameter int WORDS_PER_LINE = 40,
  parameter int LB_AW          = 6,
  parameter int LINE_SHIFT     = 2,
  parameter int BASE           = 0
) (
  input logic               clk,
  input logic               rst,
  vga_fetch_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  localparam logic [9:0] LINE_MASK = 10'((1 << LINE_SHIFT) - 1);
  localparam logic [7:0] LAST_WORD = 8'(WORDS_PER_LINE - 1);

  state_t           state_q, state_d;
  logic [7:0]       wordIdx_q, wordIdx_d;
  logic [AW-1:0]    lineBase_q, lineBase_d;
  logic             dispBank_q, dispBank_d;
  logic             rdValid_q;
  logic [LB_AW-1:0] lbAddr_q;
  logic             hostWr_q;
  logic [AW-1:0]    hostAddr_q;
  logic [DW-1:0]    hostData_q;
  logic [15:0]      stall_q;

  logic [9:0]       vNext;
  logic             trigger;
  logic             hostReady;
  logic             fetchActive;

  // A fetch is needed only on the scanline that begins a new framebuffer
  // line; the other repeats of that line reuse the buffer already loaded.
  assign vNext   = (bus.v_cnt == 10'd524) ? 10'd0 : bus.v_cnt + 10'd1;
  assign trigger = (bus.h_cnt == 10'd640) && (vNext < 10'd480) &&
                   ((vNext & LINE_MASK) == 10'd0);

  assign fetchActive = (state_q == FETCH);
  assign hostReady   = (state_q == IDLE) && !trigger;

  // Next-state logic. The line base address is latched at the trigger so
  // the burst stays consistent even if the counters move underneath it.
  always_comb begin
    state_d    = state_q;
    wordIdx_d  = wordIdx_q;
    lineBase_d = lineBase_q;
    dispBank_d = dispBank_q;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = FETCH;
          wordIdx_d  = 8'd0;
          lineBase_d = AW'(BASE) + AW'(vNext >> LINE_SHIFT) * AW'(WORDS_PER_LINE);
        end
      end
      FETCH: begin
        wordIdx_d = wordIdx_q + 8'd1;
        if (wordIdx_q == LAST_WORD) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Last read data lands in the buffer this cycle, so the flip is safe.
        state_d    = IDLE;
        dispBank_d = ~dispBank_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and fetch bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wordIdx_q  <= 8'd0;
      lineBase_q <= '0;
      dispBank_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wordIdx_q  <= wordIdx_d;
      lineBase_q <= lineBase_d;
      dispBank_q <= dispBank_d;
    end
  end

  // Read data returns one cycle after the strobe, so the line-buffer write
  // strobe and address are the read strobe and word index delayed by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid_q <= 1'b0;
      lbAddr_q  <= '0;
    end else begin
      rdValid_q <= fetchActive;
      lbAddr_q  <= LB_AW'(wordIdx_q);
    end
  end

  // Accepted host writes are issued to RAM on the following cycle. Since a
  // grant is never given when a fetch starts next, this cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hostWr_q   <= 1'b0;
      hostAddr_q <= '0;
      hostData_q <= '0;
    end else begin
      hostWr_q <= bus.host_valid && hostReady;
      if (bus.host_valid && hostReady) begin
        hostAddr_q <= bus.host_addr;
        hostData_q <= bus.host_data;
      end
    end
  end

  // Saturating host-stall counter; a clear wins over an increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if (bus.stall_clr) begin
      stall_q <= 16'd0;
    end else if (bus.host_valid && !hostReady && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.host_ready = hostReady;
  assign bus.mem_re     = fetchActive;
  assign bus.mem_we     = hostWr_q;
  assign bus.mem_addr   = fetchActive ? (lineBase_q + AW'(wordIdx_q)) :
                          (hostWr_q ? hostAddr_q : '0);
  assign bus.mem_wdata  = hostWr_q ? hostData_q : '0;
  assign bus.lb_we      = rdValid_q;
  assign bus.lb_bank    = ~dispBank_q;
  assign bus.lb_waddr   = lbAddr_q;
  assign bus.lb_wdata   = rdValid_q ? bus.mem_rdata : '0;
  assign bus.disp_bank  = dispBank_q;
  assign bus.fetch_busy = fetchActive;
  assign bus.stall_cnt  = stall_q;

endmodule

// File: tb/tb_vga_fetch_sched.sv
// ---------------------------------------------------------------------------
// tb_vga_fetch_sched
// Self-checking bench for vga_fetch_sched. A cycle-level model derived from
// the scheduling rules (trigger cycle T, fetch windows, bank flips, host
// grant/stall bookkeeping) is compared against the DUT on every cycle, and
// directed scenarios add literal checks at specific cycles.
// ---------------------------------------------------------------------------
module tb_vga_fetch_sched;

  localparam int AW    = 15;
  localparam int DW    = 16;
  localparam int W     = 40;
  localparam int LB_AW = 6;
  localparam int LS    = 2;
  localparam int BASE  = 0;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   assertCount = 0;
  int   failCount = 0;
  int   tT;

  vga_fetch_sched_if #(.AW(AW), .DW(DW), .LB_AW(LB_AW)) vif ();

  vga_fetch_sched #(
    .AW(AW), .DW(DW), .WORDS_PER_LINE(W), .LB_AW(LB_AW),
    .LINE_SHIFT(LS), .BASE(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(vif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Framebuffer content seen by reads: a fixed function of the address.
  function automatic logic [DW-1:0] romWord(input int a);
    logic [31:0] t;
    t = (a * 7) ^ 32'h5A3C;
    return t[DW-1:0];
  endfunction

  // RAM model with one-cycle read latency.
  always @(posedge clk) vif.mem_rdata <= vif.mem_re ? romWord(int'(vif.mem_addr)) : '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) stepCycle();
  endtask

  task automatic applyStimulus(input int h, input int v);
    vif.h_cnt = 10'(h);
    vif.v_cnt = 10'(v);
  endtask

  // Reference model state: trigger cycle, line, display bank, stall count,
  // and the host write waiting to reach memory.
  int          mT = -1;
  int          mLine = 0;
  int          mStall = 0;
  logic        mBank = 1'b0;
  logic        mPend = 1'b0;
  logic [31:0] mPendAddr = 0;
  logic [31:0] mPendData = 0;
  int          vn;
  int          k;
  logic        trig, expRe, expLbWe, expReady, expLbBank;

  // Per-cycle model update and comparison.
  always @(negedge clk) begin
    vn   = (int'(vif.v_cnt) == 524) ? 0 : int'(vif.v_cnt) + 1;
    trig = (int'(vif.h_cnt) == 640) && (vn < 480) && ((vn % (1 << LS)) == 0);
    if (rst) begin
      mT = -1;
      mBank = 1'b0;
      mStall = 0;
      mPend = 1'b0;
      checkOutput("rst_mem_re", vif.mem_re, 0);
      checkOutput("rst_mem_we", vif.mem_we, 0);
      checkOutput("rst_lb_we", vif.lb_we, 0);
      checkOutput("rst_mem_addr", vif.mem_addr, 0);
      checkOutput("rst_mem_wdata", vif.mem_wdata, 0);
      checkOutput("rst_lb_waddr", vif.lb_waddr, 0);
      checkOutput("rst_lb_wdata", vif.lb_wdata, 0);
      checkOutput("rst_disp_bank", vif.disp_bank, 0);
      checkOutput("rst_stall_cnt", vif.stall_cnt, 0);
      checkOutput("rst_fetch_busy", vif.fetch_busy, 0);
      checkOutput("rst_host_ready", vif.host_ready, !trig);
    end else begin
      if (mT >= 0 && cyc == mT + W + 2) mBank = ~mBank;
      if (!(mT >= 0 && cyc >= mT + 1 && cyc <= mT + W + 1) && trig) begin
        mT = cyc;
        mLine = vn >> LS;
      end
      expRe     = (mT >= 0) && (cyc >= mT + 1) && (cyc <= mT + W);
      expLbWe   = (mT >= 0) && (cyc >= mT + 2) && (cyc <= mT + W + 1);
      expReady  = !((mT >= 0) && (cyc >= mT) && (cyc <= mT + W + 1));
      expLbBank = ~mBank;
      checkOutput("mem_re", vif.mem_re, expRe);
      checkOutput("fetch_busy", vif.fetch_busy, expRe);
      checkOutput("lb_we", vif.lb_we, expLbWe);
      checkOutput("host_ready", vif.host_ready, expReady);
      checkOutput("disp_bank", vif.disp_bank, mBank);
      checkOutput("lb_bank", vif.lb_bank, expLbBank);
      checkOutput("mem_we", vif.mem_we, mPend);
      checkOutput("stall_cnt", vif.stall_cnt, mStall);
      if (expRe) begin
        k = cyc - mT - 1;
        checkOutput("fetch_addr", vif.mem_addr, (BASE + mLine * W + k) % (1 << AW));
      end
      if (expLbWe) begin
        k = cyc - mT - 2;
        checkOutput("lb_waddr", vif.lb_waddr, k);
        checkOutput("lb_wdata", vif.lb_wdata, romWord((BASE + mLine * W + k) % (1 << AW)));
      end
      if (mPend) begin
        checkOutput("host_wr_addr", vif.mem_addr, mPendAddr);
        checkOutput("host_wr_data", vif.mem_wdata, mPendData);
      end
      if (vif.stall_clr) mStall = 0;
      else if (vif.host_valid && !expReady && mStall < 65535) mStall++;
      mPend     = vif.host_valid && expReady;
      mPendAddr = 32'(vif.host_addr);
      mPendData = 32'(vif.host_data);
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0);
    vif.host_valid = 1'b0;
    vif.host_addr  = '0;
    vif.host_data  = '0;
    vif.stall_clr  = 1'b0;

    // Reset state
    repeat (3) stepCycle();
    @(negedge clk);
    checkOutput("init_disp_bank", vif.disp_bank, 0);
    checkOutput("init_mem_re", vif.mem_re, 0);
    checkOutput("init_stall_cnt", vif.stall_cnt, 0);
    checkOutput("init_host_ready", vif.host_ready, 1);
    stepCycle();
    rst = 1'b0;
    applyStimulus(100, 0);

    // Line fetch: v_cnt 3 -> framebuffer line 1, addresses 40..79
    stepCycle();
    applyStimulus(640, 3);
    tT = cyc;
    @(negedge clk);
    checkOutput("lf_ready_at_T", vif.host_ready, 0);
    stepCycle();
    applyStimulus(641, 3);
    @(negedge clk);
    checkOutput("lf_first_re", vif.mem_re, 1);
    checkOutput("lf_first_addr", vif.mem_addr, 40);
    gotoCycle(tT + 40);
    @(negedge clk);
    checkOutput("lf_last_addr", vif.mem_addr, 79);
    gotoCycle(tT + 41);
    @(negedge clk);
    checkOutput("lf_last_lb_waddr", vif.lb_waddr, 39);
    checkOutput("lf_lb_bank", vif.lb_bank, 1);
    checkOutput("lf_bank_not_yet", vif.disp_bank, 0);
    gotoCycle(tT + 42);
    @(negedge clk);
    checkOutput("lf_bank_flip", vif.disp_bank, 1);
    gotoCycle(tT + 45);

    // Repeat scanline: no fetch
    applyStimulus(640, 4);
    @(negedge clk);
    checkOutput("rep_ready", vif.host_ready, 1);
    stepCycle();
    applyStimulus(641, 4);
    @(negedge clk);
    checkOutput("rep_no_re", vif.mem_re, 0);
    stepCycle();

    // Frame wrap: v_cnt 524 -> line 0, addresses 0..39
    applyStimulus(640, 524);
    tT = cyc;
    stepCycle();
    applyStimulus(641, 524);
    @(negedge clk);
    checkOutput("wrap_first_addr", vif.mem_addr, 0);
    gotoCycle(tT + 40);
    @(negedge clk);
    checkOutput("wrap_last_addr", vif.mem_addr, 39);
    gotoCycle(tT + 45);

    // Last visible line: no fetch
    applyStimulus(640, 479);
    stepCycle();
    applyStimulus(641, 479);
    @(negedge clk);
    checkOutput("last_no_re", vif.mem_re, 0);
    stepCycle();

    // Reset in the middle of a fetch
    applyStimulus(640, 7);
    tT = cyc;
    stepCycle();
    applyStimulus(641, 7);
    gotoCycle(tT + 10);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_mem_re", vif.mem_re, 0);
    checkOutput("midrst_lb_we", vif.lb_we, 0);
    checkOutput("midrst_mem_addr", vif.mem_addr, 0);
    stepCycle();
    rst = 1'b0;
    applyStimulus(100, 7);
    @(negedge clk);
    checkOutput("midrst_ready", vif.host_ready, 1);
    checkOutput("midrst_bank", vif.disp_bank, 0);
    stepCycle();

    // Collision: host request held across the trigger
    vif.stall_clr = 1'b1;
    stepCycle();
    vif.stall_clr = 1'b0;
    stepCycle();
    applyStimulus(640, 3);
    vif.host_valid = 1'b1;
    vif.host_addr  = 15'h1234;
    vif.host_data  = 16'hBEEF;
    tT = cyc;
    stepCycle();
    applyStimulus(641, 3);
    gotoCycle(tT + 43);
    vif.host_valid = 1'b0;
    @(negedge clk);
    checkOutput("col_mem_we", vif.mem_we, 1);
    checkOutput("col_addr", vif.mem_addr, 32'h1234);
    checkOutput("col_data", vif.mem_wdata, 32'hBEEF);
    checkOutput("col_stall", vif.stall_cnt, 42);
    stepCycle();

    // Saturation: back-to-back fetches keep the host stalled
    vif.stall_clr = 1'b1;
    stepCycle();
    vif.stall_clr  = 1'b0;
    applyStimulus(640, 3);
    vif.host_valid = 1'b1;
    repeat (70000) stepCycle();
    @(negedge clk);
    checkOutput("sat_stall", vif.stall_cnt, 32'hFFFF);
    vif.stall_clr = 1'b1;
    stepCycle();
    vif.stall_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_priority", vif.stall_cnt, 0);
    vif.host_valid = 1'b0;
    applyStimulus(641, 3);
    gotoCycle(cyc + 50);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
